// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared definitions for the instruction-fetch stage:
//   - PC_W / INSTR_W      : program-counter and instruction word widths
//   - DEF_RESET_VEC       : default PC after reset and for pc_sel = PC_RST
//   - DEF_INT_VEC         : default PC for interrupt entry (pc_sel = PC_INT)
//   - pc_sel_e            : next-PC source encodings driven by decode
//   - NOP_INSTR           : all-zero instruction (opcode 00000) used as bubble
//   - if_id_t             : IF/ID pipeline register contents
//   - pc_inc()            : PC + 1, wrapping modulo 2^PC_W
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 16;

  // The return PC is rebuilt from two stack words, so the high half of the
  // PC is exactly one data word wide.
  localparam int PC_HI_W = PC_W - INSTR_W;

  localparam logic [PC_W-1:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [PC_W-1:0] DEF_INT_VEC   = 32'h0000_0002;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_RST = 2'b01,
    PC_INT = 2'b10,
    PC_TGT = 2'b11
  } pc_sel_e;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_next;
    logic               valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_next: '0, valid: 1'b0};

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Bundles every non-clock/reset signal of the fetch stage.
//   master : the surrounding pipeline (control unit, data memory, imem model)
//   slave  : fetch_stage itself
//   Signals:
//     pc_sel           next-PC source (pc_sel_e encoding)
//     fetch_pc_enable  0 holds the PC
//     freeze_cu        hold IF/ID contents
//     flush_fetch      replace IF/ID with a bubble
//     redirect_target  branch/call target
//     pop_pc2          mem_pop_data holds PC[31:16]
//     pop_pc1          mem_pop_data holds PC[15:0]; load assembled PC
//     mem_pop_data     data-memory word during pops
//     imem_rdata       instruction at imem_addr (combinational read)
//     imem_addr        current PC
//     if_id_instr      registered instruction to decode
//     if_id_pc_next    registered PC+1 of that instruction
//     if_id_valid      IF/ID holds a real instruction
// -----------------------------------------------------------------------------
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic [1:0]         pc_sel;
  logic               fetch_pc_enable;
  logic               freeze_cu;
  logic               flush_fetch;
  logic [PC_W-1:0]    redirect_target;
  logic               pop_pc2;
  logic               pop_pc1;
  logic [INSTR_W-1:0] mem_pop_data;
  logic [INSTR_W-1:0] imem_rdata;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc_next;
  logic               if_id_valid;

  modport master (
    output pc_sel, fetch_pc_enable, freeze_cu, flush_fetch, redirect_target,
    output pop_pc2, pop_pc1, mem_pop_data, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc_next, if_id_valid
  );

  modport slave (
    input  pc_sel, fetch_pc_enable, freeze_cu, flush_fetch, redirect_target,
    input  pop_pc2, pop_pc1, mem_pop_data, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc_next, if_id_valid
  );

endinterface : fetch_stage_if

// File: rtl/fetch_stage_pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
//   Program counter, return-PC high-half latch and next-PC selection.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     pc_sel_i             next-PC source (pc_sel_e)
//     fetch_pc_enable_i    0 holds the PC (unless a pop or redirect is active)
//     redirect_target_i    target used for pc_sel = PC_TGT
//     pop_pc2_i            latch mem_pop_data_i as PC high half
//     pop_pc1_i            load {high half, mem_pop_data_i} into the PC
//     mem_pop_data_i       stack word being popped
//     pc_o                 current PC
//     pc_inc_o             current PC + 1 (wrapping)
// -----------------------------------------------------------------------------
module pc_unit
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [PC_W-1:0] INT_VEC   = DEF_INT_VEC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         pc_sel_i,
  input  logic               fetch_pc_enable_i,
  input  logic [PC_W-1:0]    redirect_target_i,
  input  logic               pop_pc2_i,
  input  logic               pop_pc1_i,
  input  logic [INSTR_W-1:0] mem_pop_data_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [PC_W-1:0]    pc_inc_o
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_HI_W-1:0] pc_hi_q, pc_hi_d;
  logic [PC_W-1:0]    pc_plus1;

  assign pc_plus1 = pc_inc(pc_q);

  // Next-PC mux. A redirect is checked before the enable so that an
  // interrupt can still vector the PC while the pipeline holds it frozen.
  always_comb begin
    pc_d = pc_q;
    if (pop_pc1_i) begin
      pc_d = {pc_hi_q, mem_pop_data_i};
    end else if (pc_sel_e'(pc_sel_i) != PC_SEQ) begin
      case (pc_sel_e'(pc_sel_i))
        PC_RST:  pc_d = RESET_VEC;
        PC_INT:  pc_d = INT_VEC;
        PC_TGT:  pc_d = redirect_target_i;
        default: pc_d = pc_q;
      endcase
    end else if (fetch_pc_enable_i) begin
      pc_d = pc_plus1;
    end
  end

  // When both pops arrive together the low-half load consumes the old high
  // half, so the coincident high-half word is deliberately dropped.
  always_comb begin
    pc_hi_d = pc_hi_q;
    if (pop_pc2_i && !pop_pc1_i) begin
      pc_hi_d = mem_pop_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VEC;
      pc_hi_q <= '0;
    end else begin
      pc_q    <= pc_d;
      pc_hi_q <= pc_hi_d;
    end
  end

  assign pc_o     = pc_q;
  assign pc_inc_o = pc_plus1;

endmodule : pc_unit

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage: owns the PC (via pc_unit), drives instruction
//   memory with the current PC and holds the IF/ID pipeline register.
//   Ports:
//     clk   clock
//     rst   asynchronous active-high reset
//     bus   fetch_stage_if.slave -- control inputs, pop data, imem read data,
//           imem address and IF/ID outputs (see fetch_stage_if)
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [PC_W-1:0] INT_VEC   = DEF_INT_VEC
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus1;
  if_id_t          if_id_q, if_id_d;

  pc_unit #(
    .RESET_VEC (RESET_VEC),
    .INT_VEC   (INT_VEC)
  ) u_pc_unit (
    .clk               (clk),
    .rst               (rst),
    .pc_sel_i          (bus.pc_sel),
    .fetch_pc_enable_i (bus.fetch_pc_enable),
    .redirect_target_i (bus.redirect_target),
    .pop_pc2_i         (bus.pop_pc2),
    .pop_pc1_i         (bus.pop_pc1),
    .mem_pop_data_i    (bus.mem_pop_data),
    .pc_o              (pc),
    .pc_inc_o          (pc_plus1)
  );

  assign bus.imem_addr = pc;

  // A pop_pc1 cycle fetches from the stale PC, so that word is squashed the
  // same way a flush is. Flush outranks freeze so a frozen stage can still
  // be emptied.
  always_comb begin
    if_id_d = if_id_q;
    if (bus.flush_fetch || bus.pop_pc1) begin
      if_id_d = IF_ID_BUBBLE;
    end else if (!bus.freeze_cu) begin
      if_id_d.instr   = bus.imem_rdata;
      if_id_d.pc_next = pc_plus1;
      if_id_d.valid   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_q <= IF_ID_BUBBLE;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign bus.if_id_instr   = if_id_q.instr;
  assign bus.if_id_pc_next = if_id_q.pc_next;
  assign bus.if_id_valid   = if_id_q.valid;

endmodule : fetch_stage
